mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_if.sv | 40 ++++
 rtl/mem_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-port memory arbiter.
// The optional tie-break mode is selected by MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;

    // One-hot grant vector layout
    localparam int unsigned GNT_W = 2;
    localparam int unsigned GNT_I = 0;
    localparam int unsigned GNT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bus.
// slave = arbiter side, master = requesters plus memory.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              iReq;
    logic [ADDR_W-1:0] iAddr;
    logic              iAck;
    logic [DATA_W-1:0] iData;

    logic              dReq;
    logic              dWe;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWData;
    logic              dAck;
    logic [DATA_W-1:0] dRData;

    logic [ADDR_W-1:0] readMem;
    logic [ADDR_W-1:0] writeMem;
    logic [DATA_W-1:0] writeData;
    logic              trigRead;
    logic              trigWrite;
    logic [DATA_W-1:0] readData;

    logic              busy;

    modport slave (
        input  iReq, iAddr, dReq, dWe, dAddr, dWData, readData,
        output iAck, iData, dAck, dRData, readMem, writeMem, writeData,
               trigRead, trigWrite, busy
    );

    modport master (
        output iReq, iAddr, dReq, dWe, dAddr, dWData, readData,
        input  iAck, iData, dAck, dRData, readMem, writeMem, writeData,
               trigRead, trigWrite, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Tie-break between the fetch and data requesters: a contested request
// goes to whichever side was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic             i_req_i,
    input  logic             d_req_i,
    input  owner_e           last_grant_i,
    output logic [GNT_W-1:0] gnt_c_o
);

    always_comb begin
        gnt_c_o        = '0;
        gnt_c_o[GNT_D] = d_req_i && (!i_req_i || (last_grant_i == OWNER_I));
        gnt_c_o[GNT_I] = i_req_i && (!d_req_i || (last_grant_i == OWNER_D));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one edge-strobed memory between a fetch port and a data port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating ties; default is data-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] read_mem_q, read_mem_d;
    logic [ADDR_W-1:0] write_mem_q, write_mem_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [DATA_W-1:0] idata_q, idata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              trig_read_q, trig_read_d;
    logic              trig_write_q, trig_write_d;
    logic              iack_q, iack_d;
    logic              dack_q, dack_d;
    logic              busy_q, busy_d;

    logic [GNT_W-1:0]  gnt;
    owner_e            last_grant;

    mem_arb_pick u_pick (
        .i_req_i      (bus.iReq),
        .d_req_i      (bus.dReq),
        .last_grant_i (last_grant),
        .gnt_c_o      (gnt)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= OWNER_I;
        else       last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if ((state_q == ST_IDLE) && (gnt != '0))
            last_d = gnt[GNT_D] ? OWNER_D : OWNER_I;
    end

    assign last_grant = last_q;
`else
    // Pretending instruction always won last makes data win every tie
    assign last_grant = OWNER_I;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        read_mem_d   = read_mem_q;
        write_mem_d  = write_mem_q;
        write_data_d = write_data_q;
        idata_d      = idata_q;
        drdata_d     = drdata_q;
        trig_read_d  = 1'b0;
        trig_write_d = 1'b0;
        iack_d       = 1'b0;
        dack_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt[GNT_D]) begin
                    state_d = ST_SETUP;
                    owner_d = OWNER_D;
                    op_d    = bus.dWe ? OP_WRITE : OP_READ;
                    if (bus.dWe) begin
                        write_mem_d  = bus.dAddr;
                        write_data_d = bus.dWData;
                    end else begin
                        read_mem_d = bus.dAddr;
                    end
                end else if (gnt[GNT_I]) begin
                    state_d    = ST_SETUP;
                    owner_d    = OWNER_I;
                    op_d       = OP_READ;
                    read_mem_d = bus.iAddr;
                end
            end
            ST_SETUP: begin
                state_d      = ST_STROBE;
                trig_read_d  = (op_q == OP_READ);
                trig_write_d = (op_q == OP_WRITE);
            end
            ST_STROBE: begin
                // Memory has answered the strobe; hand the result to the owner
                state_d = ST_DONE;
                if (owner_q == OWNER_I) begin
                    iack_d  = 1'b1;
                    idata_d = bus.readData;
                end else begin
                    dack_d = 1'b1;
                    if (op_q == OP_READ) drdata_d = bus.readData;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_I;
            op_q         <= OP_READ;
            read_mem_q   <= '0;
            write_mem_q  <= '0;
            write_data_q <= '0;
            idata_q      <= '0;
            drdata_q     <= '0;
            trig_read_q  <= 1'b0;
            trig_write_q <= 1'b0;
            iack_q       <= 1'b0;
            dack_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            read_mem_q   <= read_mem_d;
            write_mem_q  <= write_mem_d;
            write_data_q <= write_data_d;
            idata_q      <= idata_d;
            drdata_q     <= drdata_d;
            trig_read_q  <= trig_read_d;
            trig_write_q <= trig_write_d;
            iack_q       <= iack_d;
            dack_q       <= dack_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.iAck      = iack_q;
    assign bus.iData     = idata_q;
    assign bus.dAck      = dack_q;
    assign bus.dRData    = drdata_q;
    assign bus.readMem   = read_mem_q;
    assign bus.writeMem  = write_mem_q;
    assign bus.writeData = write_data_q;
    assign bus.trigRead  = trig_read_q;
    assign bus.trigWrite = trig_write_q;
    assign bus.busy      = busy_q;

endmodule
